// File: rtl/mem_arbiter.sv
// Shares one RAM port between the I and D request ports of CPUS cores.
// Data beats instruction; round-robin within class; completion pulses wait low for one cycle.
module mem_arbiter #(
    parameter int unsigned CPUS    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   iaddr,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   iload,
    output logic [CPUS*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate,
    output logic                 err
);

    localparam int unsigned PW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    logic [0:0]    state, state_n;
    logic [PW-1:0] gcpu, gcpu_n;
    logic [PW-1:0] rr_ptr, rr_ptr_n;
    logic          gtype, gtype_n;
    logic          gwr, gwr_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          err_n;

    logic          gnt_active;
    logic [PW-1:0] gcpu_inc;
    logic [PW-1:0] idx;
    logic          found;

    // Granted request still being held by its requester
    always_comb begin
        gnt_active = 1'b0;
        if (gtype) begin
            gnt_active = gwr ? dWEN[gcpu] : dREN[gcpu];
        end else begin
            gnt_active = iREN[gcpu];
        end
        gcpu_inc = (gcpu == PW'(CPUS - 1)) ? '0 : PW'(gcpu + 1'b1);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            gcpu   <= '0;
            gtype  <= 1'b0;
            gwr    <= 1'b0;
            rr_ptr <= '0;
            tcnt   <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            gcpu   <= gcpu_n;
            gtype  <= gtype_n;
            gwr    <= gwr_n;
            rr_ptr <= rr_ptr_n;
            tcnt   <= tcnt_n;
            err    <= err_n;
        end
    end

    // Arbitration and transfer sequencing
    always_comb begin
        state_n  = state;
        gcpu_n   = gcpu;
        gtype_n  = gtype;
        gwr_n    = gwr;
        rr_ptr_n = rr_ptr;
        tcnt_n   = tcnt;
        err_n    = err;
        found    = 1'b0;
        idx      = '0;

        case (state)
            IDLE: begin
                for (int k = 0; k < int'(CPUS); k++) begin
                    idx = PW'((int'(rr_ptr) + k) % int'(CPUS));
                    if (!found && (dREN[idx] || dWEN[idx])) begin
                        found   = 1'b1;
                        gcpu_n  = idx;
                        gtype_n = 1'b1;
                        gwr_n   = dWEN[idx];
                    end
                end
                for (int k = 0; k < int'(CPUS); k++) begin
                    idx = PW'((int'(rr_ptr) + k) % int'(CPUS));
                    if (!found && iREN[idx]) begin
                        found   = 1'b1;
                        gcpu_n  = idx;
                        gtype_n = 1'b0;
                        gwr_n   = 1'b0;
                    end
                end
                if (found) begin
                    state_n = XFER;
                    tcnt_n  = '0;
                end
            end
            XFER: begin
                tcnt_n = TW'(tcnt + 1'b1);
                if (!gnt_active) begin
                    state_n = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    state_n  = IDLE;
                    rr_ptr_n = gcpu_inc;
                end else if (ramstate == RAM_ERROR || tcnt == TW'(TIMEOUT)) begin
                    state_n  = IDLE;
                    rr_ptr_n = gcpu_inc;
                    err_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // RAM drive and per-port wait/load, held quiet while reset is asserted
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (nRST && state == XFER && gnt_active) begin
            if (gtype) begin
                ramaddr = daddr[int'(gcpu)*DW +: DW];
                ramWEN  = gwr;
                ramREN  = !gwr;
                if (gwr) begin
                    ramstore = dstore[int'(gcpu)*DW +: DW];
                end
                if (ramstate == RAM_ACCESS) begin
                    dwait[gcpu] = 1'b0;
                    if (!gwr) begin
                        dload[int'(gcpu)*DW +: DW] = ramload;
                    end
                end
            end else begin
                ramaddr = iaddr[int'(gcpu)*DW +: DW];
                ramREN  = 1'b1;
                if (ramstate == RAM_ACCESS) begin
                    iwait[gcpu]                = 1'b0;
                    iload[int'(gcpu)*DW +: DW] = ramload;
                end
            end
        end
    end

endmodule
